// File: rtl/shift_seq_pkg.sv
// Shared encodings for the multi-byte shift sequencer: ops, FSM states and shift direction.
// The direction helper keeps the left/right op grouping in one place.
package shift_seq_pkg;

    localparam logic [2:0] OP_LSL = 3'b000;
    localparam logic [2:0] OP_LSR = 3'b001;
    localparam logic [2:0] OP_ASR = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_e;

    typedef enum logic {
        DIR_LEFT,
        DIR_RIGHT
    } dir_e;

    function automatic dir_e op_dir(input logic [2:0] op);
        return ((op == OP_LSL) || (op == OP_ROL)) ? DIR_LEFT : DIR_RIGHT;
    endfunction

    function automatic logic op_legal(input logic [2:0] op);
        return (op <= OP_ROR);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Single-position 8-bit shifter: one byte in, one byte out, with carry in and carry out.
// Purely combinational; the sequencer chains the carry between bytes.
module shift_step
    import shift_seq_pkg::*;
(
    input  logic [7:0] data,
    input  dir_e       dir,
    input  logic       cin,
    output logic [7:0] result,
    output logic       cout
);

    always_comb begin
        if (dir == DIR_LEFT) begin
            result = {data[6:0], cin};
            cout   = data[7];
        end else begin
            result = {cin, data[7:1]};
            cout   = data[0];
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-byte barrel-shift controller: shifts a BYTES-wide word one position per pass,
// processing one byte per cycle through shift_step with carry chained between bytes.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int unsigned BYTES = 4,
    parameter int unsigned AMT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*BYTES-1:0]   in_data,
    input  logic [2:0]           in_op,
    input  logic [AMT_W-1:0]     in_amt,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*BYTES-1:0]   out_data,
    output logic                 out_cout,
    output logic                 out_err
);

    localparam int unsigned W    = 8 * BYTES;
    localparam int unsigned IdxW = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(BYTES - 1);

    state_e           state_q;
    logic [W-1:0]     word_q;
    logic [2:0]       op_q;
    logic [AMT_W-1:0] pass_q;
    logic [IdxW-1:0]  idx_q;
    logic             carry_q;

    dir_e       dir;
    logic [7:0] cur_byte;
    logic [7:0] step_out;
    logic       step_cin;
    logic       step_cout;
    logic       first_cin;
    logic       first_byte;
    logic       last_byte;

    assign in_ready = (state_q == ST_IDLE);
    assign out_data = word_q;

    always_comb begin
        dir        = op_dir(op_q);
        cur_byte   = word_q[{idx_q, 3'b000} +: 8];
        first_byte = (dir == DIR_LEFT) ? (idx_q == '0) : (idx_q == LastIdx);
        last_byte  = (dir == DIR_LEFT) ? (idx_q == LastIdx) : (idx_q == '0);
        // The wrap/sign bit lives in a byte not yet touched this pass, so read it live.
        first_cin  = 1'b0;
        unique case (op_q)
            OP_ASR, OP_ROL: first_cin = word_q[W-1];
            OP_ROR:         first_cin = word_q[0];
            default:        first_cin = 1'b0;
        endcase
        step_cin   = first_byte ? first_cin : carry_q;
    end

    shift_step u_step (
        .data   (cur_byte),
        .dir    (dir),
        .cin    (step_cin),
        .result (step_out),
        .cout   (step_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            word_q    <= '0;
            op_q      <= OP_LSL;
            pass_q    <= '0;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            out_valid <= 1'b0;
            out_cout  <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        word_q  <= in_data;
                        op_q    <= in_op;
                        pass_q  <= in_amt;
                        carry_q <= 1'b0;
                        idx_q   <= (op_dir(in_op) == DIR_LEFT) ? '0 : LastIdx;
                        if (!op_legal(in_op)) begin
                            state_q   <= ST_DONE;
                            out_valid <= 1'b1;
                            out_cout  <= 1'b0;
                            out_err   <= 1'b1;
                        end else if (in_amt == '0) begin
                            state_q   <= ST_DONE;
                            out_valid <= 1'b1;
                            out_cout  <= 1'b0;
                            out_err   <= 1'b0;
                        end else begin
                            state_q <= ST_SHIFT;
                            out_err <= 1'b0;
                        end
                    end
                end
                ST_SHIFT: begin
                    word_q[{idx_q, 3'b000} +: 8] <= step_out;
                    carry_q <= step_cout;
                    if (last_byte) begin
                        pass_q <= pass_q - 1'b1;
                        idx_q  <= (dir == DIR_LEFT) ? '0 : LastIdx;
                        if (pass_q == AMT_W'(1)) begin
                            state_q   <= ST_DONE;
                            out_valid <= 1'b1;
                            out_cout  <= step_cout;
                        end
                    end else begin
                        idx_q <= (dir == DIR_LEFT) ? idx_q + 1'b1 : idx_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q   <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized self-checking bench for shift_sequencer against a whole-word arithmetic model.
module tb_shift_sequencer;

    localparam int unsigned BYTES = 4;
    localparam int unsigned W     = 8 * BYTES;
    localparam int unsigned AMT_W = 5;
    localparam int          LIMIT = 400;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_data = '0;
    logic [2:0]       in_op = '0;
    logic [AMT_W-1:0] in_amt = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [W-1:0]     out_data;
    logic             out_cout;
    logic             out_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    shift_sequencer #(
        .BYTES (BYTES),
        .AMT_W (AMT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_op     (in_op),
        .in_amt    (in_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_cout  (out_cout),
        .out_err   (out_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Whole-word reference: result, last bit out (or wrapped), error flag and latency.
    function automatic void model(input logic [2:0] op, input logic [W-1:0] d, input int a,
                                  output logic [W-1:0] res, output logic cout,
                                  output logic err, output int lat);
        res  = d;
        cout = 1'b0;
        err  = 1'b0;
        lat  = (a == 0) ? 1 : a * BYTES + 1;
        if (op > 3'd4) begin
            err = 1'b1;
            lat = 1;
        end else if (a != 0) begin
            case (op)
                3'd0: begin res = d << a; cout = d[W-a]; end
                3'd1: begin res = d >> a; cout = d[a-1]; end
                3'd2: begin res = $signed(d) >>> a; cout = d[a-1]; end
                3'd3: begin res = (d << a) | (d >> (W - a)); cout = res[0]; end
                default: begin res = (d >> a) | (d << (W - a)); cout = res[W-1]; end
            endcase
        end
    endfunction

    // Caller is #1 after an edge with the DUT idle.
    task automatic do_op(input string name, input logic [2:0] op, input logic [W-1:0] d,
                         input int a, input int hold);
        logic [W-1:0] er;
        logic ec, ee;
        int el, lat;
        model(op, d, a, er, ec, ee, el);
        check({name, ".ready"}, 64'(in_ready), 64'd1);
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        in_op     = op;
        in_data   = d;
        in_amt    = AMT_W'(a);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < LIMIT) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, ".lat"}, 64'(lat), 64'(el));
        check({name, ".data"}, 64'(out_data), 64'(er));
        check({name, ".cout"}, 64'(out_cout), 64'(ec));
        check({name, ".err"}, 64'(out_err), 64'(ee));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_data  = ~d;
            in_op    = 3'd0;
            in_amt   = AMT_W'(1);
            @(posedge clk); #1;
            check({name, ".hold_valid"}, 64'(out_valid), 64'd1);
            check({name, ".hold_data"}, 64'(out_data), 64'(er));
            check({name, ".hold_cout"}, 64'(out_cout), 64'(ec));
            check({name, ".hold_rdy"}, 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({name, ".drop"}, 64'(out_valid), 64'd0);
        check({name, ".idle"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [2:0] op;
        repeat (2) @(posedge clk);
        #1;
        check("rst.valid", 64'(out_valid), 64'd0);
        check("rst.data", 64'(out_data), 64'd0);
        check("rst.cout", 64'(out_cout), 64'd0);
        check("rst.err", 64'(out_err), 64'd0);
        check("rst.ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("lsl1", 3'd0, 32'h8000_0001, 1, 0);
        do_op("asr4", 3'd2, 32'h8000_00F0, 4, 0);
        do_op("ror1", 3'd4, 32'h0000_0001, 1, 0);
        do_op("rol1", 3'd3, 32'h8000_0001, 1, 0);
        do_op("lsr0", 3'd1, 32'h1234_5678, 0, 0);
        do_op("bp", 3'd1, 32'hFFFF_FFFF, 31, 5);
        do_op("ill", 3'd7, 32'hDEAD_BEEF, 3, 0);

        // Reset in the middle of a long shift discards it.
        in_valid = 1'b1;
        in_op    = 3'd0;
        in_data  = 32'hA5A5_0F0F;
        in_amt   = AMT_W'(20);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst.valid", 64'(out_valid), 64'd0);
        check("midrst.data", 64'(out_data), 64'd0);
        check("midrst.ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        do_op("post_rst", 3'd0, 32'h0000_0001, 3, 0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0) op = 3'($urandom_range(5, 7));
            else op = 3'($urandom_range(0, 4));
            do_op("rand", op, W'($urandom), int'($urandom_range(0, W - 1)),
                  int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Multi-byte barrel-shift controller for the 8-bit shift datapath. It accepts a BYTES-wide word, an op and an amount, then steps the word through one 8-bit single-position shift stage one byte per cycle, chaining carry between bytes and repeating for each shift position. It sits between the ALU decode stage and the register writeback path, and exposes valid/ready handshakes on both sides.

Parameters:
BYTES, 4, number of 8-bit bytes in the operand word; W = 8*BYTES.
AMT_W, 5, shift-amount width; must equal clog2(W).

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  synchronous, active-low reset.
in_valid  input  1  request valid.
in_ready  output  1  sequencer can accept a request.
in_data  input  W  operand word.
in_op  input  3  000 LSL, 001 LSR, 010 ASR, 011 ROL, 100 ROR; 101-111 illegal.
in_amt  input  AMT_W  shift distance, 0..W-1.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
out_data  output  W  shifted word.
out_cout  output  1  last bit shifted out of the word (rotates: last bit wrapped).
out_err  output  1  illegal op flag, valid with out_valid.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; out_valid=0, out_data=0, out_cout=0, out_err=0, in_ready=1 after the edge. Reset takes priority over all events, including mid-SHIFT and mid-DONE; any in-flight result is discarded.
- States: IDLE, SHIFT, DONE. in_ready=1 only in IDLE.
- IDLE: on in_valid&in_ready, latch data/op/amt into internal registers.
  - Illegal op -> DONE with out_data=in_data, out_cout=0, out_err=1.
  - amt=0 -> DONE with out_data=in_data, out_cout=0, out_err=0.
  - Otherwise -> SHIFT with pass counter=amt and byte index = 0 (left ops) or BYTES-1 (right ops).
- SHIFT: each cycle processes one byte in place through shift_step.
  - Left ops walk byte 0 upward; right ops walk byte BYTES-1 downward.
  - First-byte cin of each pass, read live from the word register:
    - LSL/LSR: 0.
    - ASR: word[W-1].
    - ROL: word[W-1], still unmodified this pass.
    - ROR: word[0], still unmodified this pass.
  - Later bytes take cin from the carry register, which is written with the cout of the previous byte step.
  - After the last byte of a pass, decrement the pass counter. If it reaches 0, go to DONE with out_cout=carry and out_data=word; otherwise restart at the first byte.
- Latency from the accept edge to out_valid=1: amt*BYTES+1 cycles when amt>0; 1 cycle when amt=0 or op is illegal.
- DONE: out_valid=1; out_data, out_cout and out_err are held stable while out_ready=0. On out_valid&out_ready, go to IDLE and drop out_valid next cycle. A new request cannot be accepted in the same cycle.
- in_valid outside IDLE is ignored; the internal registers are not disturbed.
- shift_step semantics:
  - Left: out={in[6:0],cin}, cout=in[7].
  - Right: out={cin,in[7:1]}, cout=in[0].
  - Purely combinational.

Decomposition:
- Shared package shift_seq_pkg: op encodings (OP_LSL..OP_ROR), state encodings (ST_IDLE, ST_SHIFT, ST_DONE), and a helper returning op direction (left/right).
- Sub-module shift_step: 8-bit single-position shifter with dir, cin and cout. The sequencer owns the byte mux/demux, counters, carry register and FSM.

Test Plan:
- LSL 0x80000001 amt=1, out_ready=1 -> out_data=0x00000002, out_cout=1, out_valid asserted exactly 5 cycles after accept.
- ASR 0x800000F0 amt=4 -> out_data=0xF800000F, out_cout=0, latency 17; then ROR 0x00000001 amt=1 -> 0x80000000, out_cout=1.
- ROL 0x80000001 amt=1 -> 0x00000003, out_cout=1; LSR 0x12345678 amt=0 -> 0x12345678, out_cout=0, latency 1.
- Backpressure: LSR 0xFFFFFFFF amt=31 with out_ready=0 for 5 cycles after out_valid -> out_data=0x00000001 and out_cout=1 held stable, in_ready=0, a concurrent in_valid is ignored; then out_ready=1 -> IDLE.
- Reset mid-SHIFT (LSL amt=20, rst_n=0 at cycle 10) -> next edge out_valid=0, out_data=0, in_ready=1; a following LSL 0x00000001 amt=3 -> 0x00000008.
- Illegal op 3'b111 with data 0xDEADBEEF -> out_err=1, out_data=0xDEADBEEF, out_cout=0, latency 1.
